// File: rtl/restore_div_pkg.sv
// Shared constants and result record for the restoring-divider quotient collector.
package restore_div_pkg;

    localparam int DEF_WIDTH = 4;

    function automatic int STAGES_OF(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int REM_W_OF(input int width);
        return 3 * width;
    endfunction

    localparam int DEF_STAGES = STAGES_OF(DEF_WIDTH);
    localparam int REM_W      = REM_W_OF(DEF_WIDTH);

    typedef struct packed {
        logic [DEF_STAGES-1:0] quot;
        logic [DEF_WIDTH-1:0]  rem;
        logic                  dz;
    } res_t;

endpackage

// File: rtl/restore_res_fifo.sv
// Result FIFO for the quotient collector; a push into a full FIFO succeeds only with a same-cycle pop.
module restore_res_fifo
    import restore_div_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/restore_quot_collect.sv
// Deskews per-stage quotient bits of a restoring divider and queues aligned results.
// Optional divide-by-zero tagging is built when RESTORE_COLLECT_DZ_EN is defined.
module restore_quot_collect
    import restore_div_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = STAGES_OF(WIDTH),
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [STAGES-1:0]        q_bits,
    input  logic [3*WIDTH-1:0]       rem_din,
`ifdef RESTORE_COLLECT_DZ_EN
    input  logic                     in_dz,
    output logic                     out_dz,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [STAGES-1:0]        out_quot,
    output logic [WIDTH-1:0]         out_rem,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int VD = STAGES - 1;
`ifdef RESTORE_COLLECT_DZ_EN
    localparam int DW = STAGES + WIDTH + 1;
`else
    localparam int DW = STAGES + WIDTH;
`endif

    logic [STAGES-1:0] aligned_quot;
    logic [VD-1:0]     vld_sr;
    logic              aligned_vld;
    logic [DW-1:0]     push_data;
    logic [DW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              rem_unused;

    assign rem_unused = ^rem_din[3*WIDTH-1:WIDTH];

    // Stage i fires i cycles after stage 0, so it waits STAGES-1-i cycles to meet the remainder.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_deskew
            localparam int D = STAGES - 1 - gi;
            if (D == 0) begin : g_direct
                assign aligned_quot[STAGES-1-gi] = q_bits[gi];
            end else if (D == 1) begin : g_one
                logic dly;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) dly <= 1'b0;
                    else        dly <= q_bits[gi];
                end
                assign aligned_quot[STAGES-1-gi] = dly;
            end else begin : g_chain
                logic [D-1:0] dly;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) dly <= '0;
                    else        dly <= {dly[D-2:0], q_bits[gi]};
                end
                assign aligned_quot[STAGES-1-gi] = dly[D-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= {vld_sr[VD-2:0], in_valid};
    end

    assign aligned_vld = vld_sr[VD-1];

`ifdef RESTORE_COLLECT_DZ_EN
    logic [VD-1:0] dz_sr;
    logic          aligned_dz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dz_sr <= '0;
        else        dz_sr <= {dz_sr[VD-2:0], in_valid & in_dz};
    end

    assign aligned_dz = dz_sr[VD-1];
    assign push_data  = {aligned_dz,
                         aligned_dz ? {STAGES{1'b1}} : aligned_quot,
                         rem_din[WIDTH-1:0]};
    assign {out_dz, out_quot, out_rem} = fifo_dout;
`else
    assign push_data = {aligned_quot, rem_din[WIDTH-1:0]};
    assign {out_quot, out_rem} = fifo_dout;
`endif

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    restore_res_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (aligned_vld),
        .din    (push_data),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    // A result is lost only when the FIFO is full and nothing leaves in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (aligned_vld && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: doc/restore_quot_collect.md
RESTORE_QUOT_COLLECT -- requirements
Module: restore_quot_collect

Interface
REQ-001 Parameter WIDTH, default 4, SHALL be the divisor width shared with the divider stage cells.
REQ-002 Parameter STAGES, default 2*WIDTH+1, SHALL be the number of cascaded stage cells, which is also the quotient width.
REQ-003 Parameter DEPTH, default 4, SHALL be the output FIFO depth; it SHALL be a power of two and at least 2.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 in_valid  in  1  SHALL mark a token whose stage-0 quotient bit is present on q_bits[0] this cycle.
REQ-007 q_bits  in  STAGES  SHALL carry one bit per stage: bit i is stage i's registered quotient output, and stage 0 has the largest shift.
REQ-008 rem_din  in  3*WIDTH  SHALL be the last stage's registered remainder output.
REQ-009 out_valid  out  1, out_ready  in  1  SHALL form the result handshake.
REQ-010 out_quot  out  STAGES, out_rem  out  WIDTH  SHALL be the FIFO head result.
REQ-011 overflow  out  1  SHALL be the sticky dropped-result flag; level  out  $clog2(DEPTH)+1  SHALL be the FIFO occupancy.

Function
REQ-012 The block SHALL delay q_bits[i] by STAGES-1-i cycles, so that all bits of one token align with that token's rem_din.
REQ-013 The block SHALL delay in_valid by STAGES-1 cycles through a shift register to form the aligned valid.
REQ-014 The aligned quotient SHALL map stage i to out_quot[STAGES-1-i], so stage 0 is the MSB.
REQ-015 The aligned remainder SHALL be rem_din[WIDTH-1:0]; upper bits SHALL be ignored.
REQ-016 For in_valid at cycle t, the result SHALL be pushed at the end of cycle t+STAGES-1.
REQ-017 If the FIFO is empty beforehand, out_valid SHALL be high at cycle t+STAGES.
REQ-018 A pop SHALL occur when out_valid and out_ready are both high; outputs SHALL show the next entry on the following cycle.
REQ-019 The upstream pipeline cannot stall; tokens SHALL be accepted on consecutive cycles with no bubble required.
REQ-020 Push into a full FIFO with no pop in the same cycle SHALL drop the result, set overflow, and leave FIFO contents unchanged.
REQ-021 Push and pop in the same cycle while full SHALL both succeed; overflow SHALL not be set and level SHALL stay DEPTH.
REQ-022 Push and pop in the same cycle while empty SHALL be impossible, since out_valid is low; the push SHALL be the only operation.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-024 out_quot and out_rem SHALL hold their value while out_valid is high and out_ready is low.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously clear the delay lines, valid shift register, pointers, level, overflow and out_valid.
REQ-026 Reset SHALL zero out_quot and out_rem.
REQ-027 Tokens in flight at reset SHALL be discarded; no result SHALL appear after reset release unless in_valid is asserted anew.
REQ-028 overflow SHALL clear only on reset.

Configuration
REQ-029 Macro RESTORE_COLLECT_DZ_EN defined: the block SHALL provide ports in_dz (in, 1) and out_dz (out, 1).
REQ-030 With the macro defined, in_dz SHALL be sampled with in_valid and delayed alongside it.
REQ-031 With the macro defined, a result with dz set SHALL store out_quot all-ones and out_rem unchanged, with out_dz high.
REQ-032 Macro undefined: in_dz and out_dz SHALL be absent and no dz storage SHALL be built; all other behaviour SHALL be identical.

Structure
REQ-033 Package restore_div_pkg SHALL hold the derived constants STAGES_OF(WIDTH) and REM_W = 3*WIDTH, and the result struct {quot, rem, dz}.
REQ-034 The FIFO SHALL be a sub-module named restore_res_fifo (parameters DATA_W and DEPTH) that exposes push, pop, full, empty and level.
REQ-035 Deskew and valid delay SHALL stay in the top module.

Verification (WIDTH=4, STAGES=9, DEPTH=4)
REQ-036 Single token: drive bits of 100/7 (quotient 14, remainder 2) at the correct skew -> out_quot=9'd14, out_rem=4'd2, out_valid at t+9.
REQ-037 Back-to-back tokens 100/7, 255/15, 0/3 with out_ready=1 -> results (14,2), (17,0), (0,0) on three consecutive cycles, in order.
REQ-038 out_ready=0 with six consecutive tokens -> level reaches 4, overflow=1 after the fifth, and the first four results pop in order once out_ready=1.
REQ-039 FIFO full with out_ready=1 and a new token arriving -> no overflow, level stays 4, head advances by one.
REQ-040 rst_n pulsed low while three tokens are in flight -> out_valid=0, level=0, and no result appears during 20 idle cycles.
REQ-041 With RESTORE_COLLECT_DZ_EN defined, a token with in_dz=1 -> out_quot=9'h1FF and out_dz=1.
